// File: rtl/i2s_rx.sv
// i2s_rx: Philips-format I2S receiver running on clk_sys.
// Oversamples the asynchronous sclk/lrclk/sdata pins, deserializes each word,
// tracks word-length consistency to decide lock, and delivers left/right
// sample pairs with a one-cycle strobe.
module i2s_rx #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             sclk,
  input  logic             lrclk,
  input  logic             sdata,
  output logic [WIDTH-1:0] left_chan,
  output logic [WIDTH-1:0] right_chan,
  output logic             sample_valid,
  output logic             locked,
  output logic [5:0]       frame_bits
);

  localparam int            TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TPRE = TW'(TIMEOUT - 1);

  // Pin conditioning
  logic sclk_s1, sclk_s2, sclk_h;
  logic lr_s1, lr_s2;
  logic sd_s1, sd_s2;
  logic sclk_rise;

  // Deserializer and lock state
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] left_hold;
  logic [5:0]       cnt;
  logic [5:0]       cnt_inc;
  logic [2:0]       lock_cnt;
  logic [2:0]       lock_next;
  logic [TW-1:0]    tcnt;
  logic             lr_prev;
  logic             lr_change;
  logic             partial;
  logic             left_seen;
  logic             len_ok;
  logic             locked_after;

  // Two-stage synchronizers plus an sclk history stage for edge detection.
  // NOTE: these are pure delay lines with no reset; clearing them on a short
  // mid-stream reset would fake an sclk edge once the pin value reappears.
  always_ff @(posedge clk_sys) begin
    sclk_s1 <= sclk;
    sclk_s2 <= sclk_s1;
    sclk_h  <= sclk_s2;
    lr_s1   <= lrclk;
    lr_s2   <= lr_s1;
    sd_s1   <= sdata;
    sd_s2   <= sd_s1;
  end

  assign sclk_rise    = sclk_s2 & ~sclk_h;
  assign lr_change    = lr_s2 != lr_prev;
  assign locked_after = lock_next == 3'd4;

  // Next shift-register contents, saturating bit count and lock-count update
  // for the bit arriving on the current sclk rise.
  // NOTE: every output of this block gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    shreg_next = shreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(cnt) == WIDTH - 1 - i) shreg_next[i] = sd_s2;
    end
    cnt_inc = (cnt == 6'd63) ? 6'd63 : cnt + 6'd1;
    len_ok  = (cnt_inc >= 6'd8) && (cnt_inc == frame_bits);
    if (!len_ok)                lock_next = 3'd1;
    else if (lock_cnt == 3'd4)  lock_next = 3'd4;
    else                        lock_next = lock_cnt + 3'd1;
  end

  // Word assembly, finalize, lock tracking, delivery and timeout.
  // NOTE: state registers use non-blocking assignments so every read in this
  // block sees the value from before the clock edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      frame_bits   <= '0;
      shreg        <= '0;
      cnt          <= '0;
      lock_cnt     <= '0;
      tcnt         <= '0;
      partial      <= 1'b1;
      left_seen    <= 1'b0;
      left_hold    <= '0;
      // Track the live word select so a reset mid-word does not look like
      // a channel change on the next bit.
      lr_prev      <= lr_s2;
    end else begin
      sample_valid <= 1'b0;
      if (sclk_rise) begin
        tcnt    <= '0;
        lr_prev <= lr_s2;
        if (!lr_change) begin
          shreg <= shreg_next;
          cnt   <= cnt_inc;
        end else begin
          // The bit on a word-select change is the LSB of the previous word.
          shreg      <= '0;
          cnt        <= '0;
          frame_bits <= cnt_inc;
          if (partial) begin
            partial <= 1'b0;
          end else begin
            lock_cnt <= lock_next;
            locked   <= locked_after;
            if (!lr_prev) begin
              left_hold <= shreg_next;
              left_seen <= 1'b1;
            end else begin
              left_seen <= 1'b0;
              if (locked_after && left_seen) begin
                left_chan    <= left_hold;
                right_chan   <= shreg_next;
                sample_valid <= 1'b1;
              end
            end
          end
        end
      end else if (tcnt != TMAX) begin
        tcnt <= tcnt + 1'b1;
        if (tcnt == TPRE) begin
          // Bit clock lost: drop lock and treat the next word as a fragment.
          locked    <= 1'b0;
          lock_cnt  <= '0;
          partial   <= 1'b1;
          shreg     <= '0;
          cnt       <= '0;
          left_seen <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: drives a word-level I2S stream into i2s_rx, predicts deliveries
// with a word-level reference model and compares through a scoreboard queue.
module tb_i2s_rx;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        sclk    = 1'b0;
  logic        lrclk   = 1'b0;
  logic        sdata   = 1'b0;
  logic [15:0] left_chan;
  logic [15:0] right_chan;
  logic        sample_valid;
  logic        locked;
  logic [5:0]  frame_bits;

  i2s_rx #(.WIDTH(16), .TIMEOUT(255)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .left_chan    (left_chan),
    .right_chan   (right_chan),
    .sample_valid (sample_valid),
    .locked       (locked),
    .frame_bits   (frame_bits)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [5:0]  fb;
  } exp_t;

  exp_t sb_q[$];

  // Word-level reference model
  bit          m_partial;
  int          m_lock;
  int          m_prev_len;
  logic [15:0] m_hold;
  bit          m_seen;
  bit          m_locked;
  int          n_deliv = 0;

  function automatic logic [15:0] justify(input logic [31:0] val, input int n);
    logic [31:0] v;
    v = val & ((32'd1 << n) - 32'd1);
    if (n >= 16) v = v >> (n - 16);
    else         v = v << (16 - n);
    return v[15:0];
  endfunction

  task automatic model_reset();
    m_partial  = 1'b1;
    m_lock     = 0;
    m_prev_len = 0;
    m_seen     = 1'b0;
    m_locked   = 1'b0;
  endtask

  task automatic model_timeout();
    m_partial = 1'b1;
    m_lock    = 0;
    m_seen    = 1'b0;
    m_locked  = 1'b0;
  endtask

  task automatic model_finalize(input bit chan, input int n, input logic [31:0] val);
    int          len;
    logic [15:0] w;
    exp_t        e;
    len = (n > 63) ? 63 : n;
    w   = justify(val, n);
    if (m_partial) begin
      m_partial  = 1'b0;
      m_prev_len = len;
      return;
    end
    if (len >= 8 && len == m_prev_len) m_lock = (m_lock >= 4) ? 4 : m_lock + 1;
    else                               m_lock = 1;
    m_prev_len = len;
    m_locked   = (m_lock == 4);
    if (!chan) begin
      m_hold = w;
      m_seen = 1'b1;
    end else begin
      if (m_locked && m_seen) begin
        e.l  = m_hold;
        e.r  = w;
        e.fb = 6'(len);
        sb_q.push_back(e);
      end
      m_seen = 1'b0;
    end
  endtask

  // Output monitor: every strobe must match the oldest predicted delivery.
  bit          prev_sv = 1'b0;
  exp_t        got_e;
  logic [15:0] last_l = '0;
  logic [15:0] last_r = '0;

  always @(negedge clk_sys) begin
    if (sample_valid) begin
      check("valid_while_locked", locked, 1'b1);
      check("valid_back_to_back", prev_sv, 1'b0);
      if (sb_q.size() == 0) begin
        check("unexpected_valid", sample_valid, 1'b0);
      end else begin
        got_e = sb_q.pop_front();
        check("left_chan", left_chan, got_e.l);
        check("right_chan", right_chan, got_e.r);
        check("frame_bits", frame_bits, got_e.fb);
        last_l = got_e.l;
        last_r = got_e.r;
        n_deliv++;
      end
    end
    prev_sv = sample_valid;
  end

  // Stream generator state
  bit          have_prev  = 1'b0;
  bit          prev_chan  = 1'b0;
  int          prev_n     = 0;
  logic [31:0] prev_val   = '0;
  logic        prev_bit   = 1'b0;

  // One bit slot: 16 cycles low, 16 high. Optionally pulses reset in the low
  // half and optionally checks lock at the end of the slot.
  task automatic slot(input logic lr, input logic d, input bit chk_lock, input int rst_at);
    lrclk = lr;
    sdata = d;
    sclk  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_sys);
      if (i == rst_at) begin
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        model_reset();
        check("rst_left", left_chan, 16'h0);
        check("rst_right", right_chan, 16'h0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_frame_bits", frame_bits, 6'h0);
      end
    end
    sclk = 1'b1;
    repeat (16) @(negedge clk_sys);
    if (chk_lock) check("locked", locked, m_locked);
  endtask

  // I2S word: word select changes one slot before the MSB, so the first slot
  // of this word carries the previous word's LSB.
  task automatic send_word(input bit chan, input int n, input logic [31:0] val, input int rst_slot);
    bit fin;
    for (int i = n - 1; i >= 0; i--) begin
      fin = (i == n - 1) && have_prev;
      if (fin) model_finalize(prev_chan, prev_n, prev_val);
      slot(chan, prev_bit, fin, ((n - 1 - i) == rst_slot) ? 4 : -1);
      prev_bit = val[i];
    end
    have_prev = 1'b1;
    prev_chan = chan;
    prev_n    = n;
    prev_val  = val;
  endtask

  task automatic send_frames(input int frames, input int n, input logic [31:0] lw, input logic [31:0] rw);
    for (int f = 0; f < frames; f++) begin
      send_word(1'b0, n, lw, -1);
      send_word(1'b1, n, rw, -1);
    end
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #(20_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (5) @(negedge clk_sys);
    check("init_left", left_chan, 16'h0);
    check("init_right", right_chan, 16'h0);
    check("init_valid", sample_valid, 1'b0);
    check("init_locked", locked, 1'b0);
    check("init_frame_bits", frame_bits, 6'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);

    // Lock and deliver with 16-bit words
    send_frames(5, 16, 32'h1234, 32'hABCD);

    // Long words truncate to the top 16 bits
    send_frames(5, 24, 32'h123456, 32'hFEDCBA);

    // Short words are left-justified
    send_frames(5, 12, 32'hABC, 32'h123);

    // Relock at 16 bits, then stall the bit clock
    send_frames(5, 16, 32'h5A5A, 32'hC3C3);
    sclk = 1'b0;
    repeat (200) @(negedge clk_sys);
    check("stall_locked_early", locked, m_locked);
    repeat (100) @(negedge clk_sys);
    model_timeout();
    check("stall_locked_late", locked, 1'b0);
    check("stall_left_hold", left_chan, last_l);
    check("stall_right_hold", right_chan, last_r);
    send_frames(5, 16, 32'h0F0F, 32'hF0F0);

    // One 17-bit left word breaks lock
    send_word(1'b0, 17, 32'h12345, -1);
    send_word(1'b1, 16, 32'h7777, -1);
    send_frames(4, 16, 32'h1111, 32'h2222);

    // Reset during the MSB half of a right word
    send_word(1'b0, 16, 32'h3333, -1);
    send_word(1'b1, 16, 32'h4444, 3);
    send_frames(4, 16, 32'h9876, 32'h6789);

    // Trailing left word finalizes the last right word
    send_word(1'b0, 16, 32'h0000, -1);
    repeat (10) @(negedge clk_sys);
    check("sb_drained", sb_q.size(), 0);
    check("deliveries_seen", n_deliv >= 10, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Serial audio receiver: the receiving end of the I2S link the sound path already drives.
- Runs on clk_sys and oversamples asynchronous sclk/lrclk/sdata pins.
- Deserializes Philips-format I2S frames into parallel left/right samples with a one-cycle strobe per stereo frame.
- Use cases: external audio or tape-in source, or loopback checking of the transmitter.

Parameters:
- WIDTH, 16: output sample width in bits.
- TIMEOUT, 255: clk_sys cycles without an sclk rising edge before lock is dropped.

Ports:
- clk_sys  in  1  system clock (96 MHz).
- reset  in  1  synchronous, active-high reset.
- sclk  in  1  I2S bit clock, asynchronous.
- lrclk  in  1  I2S word select, asynchronous; 0 = left, 1 = right.
- sdata  in  1  I2S serial data, asynchronous, MSB first.
- left_chan  out  WIDTH  last complete left sample.
- right_chan  out  WIDTH  last complete right sample.
- sample_valid  out  1  one-cycle strobe when left_chan/right_chan update.
- locked  out  1  stream is consistent and samples are being delivered.
- frame_bits  out  6  bit count of the last finalized word, saturating at 63.

Behaviour:
- Reset: left_chan=0, right_chan=0, sample_valid=0, locked=0, frame_bits=0. Internal shift register, bit counter, lock counter and timeout counter are cleared. The partial flag is set. Reset dominates every other event.
- Input conditioning:
  - Each pin passes through a 2-FF synchronizer, then one history register.
  - An sclk rise is detected when the synced value is 1 and the history value is 0.
  - Pin-to-detect latency is 3 clk_sys cycles.
  - sclk high and low phases must each be at least 2 clk_sys cycles; faster clocks are out of spec.
- On each sclk rise, sample the synced sdata (bit) and lrclk (lr).
- Word select unchanged (lr == lr_prev):
  - If cnt < WIDTH, write bit into shreg[WIDTH-1-cnt].
  - Bits with index >= WIDTH are discarded.
  - cnt increments, saturating at 63.
- Word select changed (lr != lr_prev): the current bit is the LSB of the previous word, per I2S.
  - Store it under the same rule as above, then finalize the word for channel lr_prev.
  - Clear shreg and set cnt=0. The next sclk rise is the MSB of the new word.
  - Set lr_prev <= lr.
- Finalize:
  - frame_bits <= cnt+1 (saturating at 63).
  - Short words (fewer than WIDTH bits) are left-justified with zero LSBs. Long words are truncated to the top WIDTH bits.
  - If the partial flag is set, discard the word, clear the flag, and leave the lock counter unchanged.
  - Otherwise, if the word length is >= 8 and equals the previous finalized length, increment the lock counter (saturating at 4). Any other length sets the lock counter to 1 and drops locked.
  - locked=1 when the lock counter reaches 4.
- Sample delivery:
  - A finalized left word is stored in left_hold.
  - A finalized right word, when locked=1 after this finalize's lock update and a left word has been captured since the last delivery, loads right_chan <= word and left_chan <= left_hold together.
  - sample_valid pulses high on the cycle after the finalizing sclk rise was detected.
  - A right word with no preceding left word in the same frame gives no delivery.
- Timeout:
  - tcnt increments every clk_sys cycle and is cleared on each sclk rise. It saturates at TIMEOUT.
  - When tcnt reaches TIMEOUT: locked=0, lock counter=0, partial flag set, shreg/cnt cleared.
  - left_chan/right_chan hold their last values. No sample_valid until relock.
  - An sclk rise in the same cycle as the timeout wins: the counter is cleared and no timeout occurs.
- sample_valid never asserts while locked=0, and never for two consecutive cycles.

Test Plan:
- Lock and deliver: 16-bit frames at sclk = clk_sys/32, alternating left 0x1234 / right 0xABCD.
  - locked rises at the 4th consistent finalized word.
  - The first sample_valid follows the next right word, with left_chan=0x1234, right_chan=0xABCD and frame_bits=16.
  - Exactly one pulse per frame thereafter.
- Long words: 24-bit words, left 0x123456 / right 0xFEDCBA -> left_chan=0x1234, right_chan=0xFEDC, frame_bits=24.
- Short words: 12-bit words, left 0xABC / right 0x123 -> left_chan=0xABC0, right_chan=0x1230, frame_bits=12.
- Clock stall: after lock, hold sclk low for 300 clk_sys cycles.
  - locked falls at cycle 255 of the stall; outputs hold; no strobe.
  - When the clock resumes, the first word is discarded and relock needs 4 further consistent words.
- Length glitch: after lock, inject one 17-bit left word -> locked drops immediately and relocks only after 4 consistent 16-bit words.
- Reset mid-word: assert reset for 1 cycle during the MSB half of a right word.
  - All outputs go to 0 the next cycle.
  - The partial word is not delivered and the lock sequence restarts.
